// File: rtl/chan_encoder.sv
// Precoding channel encoder: FIFO-buffered data bits become 2-bit trellis symbols
// (f ^ s == previous f), sent serially one bit per clock, with filler symbols when idle.
module chan_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             inject_err,
  output logic             sym_out,
  output logic             sym_strobe,
  output logic             idle_sym,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Two-state symbol phase: FIRST edges start a symbol, SECOND edges send its second bit.
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t                phase;
  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  prev_f;
  logic                  prev_s;
  logic                  s_hold;
  logic                  err_pend;
  logic                  err_arm;

  logic push;
  logic pop;
  logic d_bit;
  logic f_next;
  logic s_next;

  // Handshake: din is taken on any clock edge where din_valid && din_ready; din_ready
  // depends only on the registered level, never on din_valid.
  assign din_ready = (fifo_level < LVL_W'(FIFO_DEPTH));

  always_comb begin
    push   = din_valid && din_ready;
    pop    = (phase == PH_FIRST) && (fifo_level != '0);
    d_bit  = pop ? fifo_mem[rd_ptr] : 1'b0;
    f_next = d_bit ^ prev_s;
    s_next = f_next ^ prev_f;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase      <= PH_FIRST;
      fifo_mem   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      prev_f     <= 1'b0;
      prev_s     <= 1'b0;
      s_hold     <= 1'b0;
      err_pend   <= 1'b0;
      err_arm    <= 1'b0;
      sym_out    <= 1'b0;
      sym_strobe <= 1'b0;
      idle_sym   <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= din;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: ;
      endcase

      if (phase == PH_FIRST) begin
        phase      <= PH_SECOND;
        sym_out    <= f_next;
        sym_strobe <= 1'b1;
        idle_sym   <= !pop;
        s_hold     <= s_next;
        prev_f     <= f_next;
        prev_s     <= s_next;
        err_arm    <= err_pend | inject_err;
        err_pend   <= 1'b0;
      end else begin
        // Corruption only touches the wire; prev_f/prev_s keep the true trellis state.
        phase      <= PH_FIRST;
        sym_out    <= s_hold ^ err_arm;
        sym_strobe <= 1'b0;
        err_arm    <= 1'b0;
        err_pend   <= err_pend | inject_err;
      end
    end
  end

endmodule
